display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 96 +++++++++
 tb/tb_display_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// display_scan: time-multiplexed driver for a 4-digit 7-segment display.
// Each digit owns a slot of DIGIT_TICKS cycles. The first BLANK_TICKS cycles
// of each slot keep every digit off so the previous pattern cannot ghost onto
// the next digit. The frame is latched once per scan at (digit 0, tick 0), so
// a display_in update never tears a frame that is already being shown.
module display_scan #(
    parameter logic [27:0] DIGIT_TICKS    = 28'd6750,
    parameter logic [27:0] BLANK_TICKS    = 28'd64,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] display_in,
    input  logic        en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam logic [27:0] LAST_TICK = DIGIT_TICKS - 28'd1;
    // Output words that mean "nothing lit" for the selected polarities; an
    // active-high pattern XORed with these gives the physical drive level.
    localparam logic [6:0]  SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]  AN_OFF    = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

    logic [27:0] t_reg, t_next;
    logic [1:0]  d_reg, d_next;
    logic [27:0] frame_reg, frame_next;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;
    logic        done_next;
    logic        slot_on;
    logic [6:0]  digit_pat [4];

    // Split the latched frame into one 7-bit pattern per digit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_pat[gi] = frame_reg[7*gi +: 7];
        end
    endgenerate

    // Slot phase: with no blanking interval the whole slot is ON.
    generate
        if (BLANK_TICKS == 28'd0) begin : g_no_blank
            assign slot_on = 1'b1;
        end else begin : g_blank
            assign slot_on = (t_reg >= BLANK_TICKS);
        end
    endgenerate

    // State and output registers; reset aborts the scan immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_reg      <= 28'd0;
            d_reg      <= 2'd0;
            frame_reg  <= 28'd0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            t_reg      <= t_next;
            d_reg      <= d_next;
            frame_reg  <= frame_next;
            seg        <= seg_next;
            an         <= an_next;
            frame_done <= done_next;
        end
    end

    // Next-state: tick/digit counters and the once-per-scan frame capture.
    always_comb begin
        t_next     = t_reg + 28'd1;
        d_next     = d_reg;
        frame_next = frame_reg;
        if (t_reg == LAST_TICK) begin
            t_next = 28'd0;
            d_next = d_reg + 2'd1;
        end
        if (d_reg == 2'd0 && t_reg == 28'd0) begin
            frame_next = display_in;
        end
    end

    // Output decode: en only gates the drive, it never stalls the scan.
    always_comb begin
        seg_next  = SEG_OFF;
        an_next   = AN_OFF;
        done_next = (d_reg == 2'd3) && (t_reg == LAST_TICK);
        if (en && slot_on) begin
            seg_next = digit_pat[d_reg] ^ SEG_OFF;
            an_next  = (4'b0001 << d_reg) ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Testbench for display_scan with short slots (8 cycles, 2 blank). A second
// instance uses active-high polarities and no blanking. A behavioural model
// pushes the expected outputs of every edge into a scoreboard queue before
// the edge; they are popped and compared 1 ns after the edge.
module tb_display_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic [27:0] display_in;
    logic [27:0] display_in2;
    logic [6:0]  seg, seg2;
    logic [3:0]  an, an2;
    logic        frame_done, frame_done2;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int fd_count = 0;

    // Model state
    int          tm;
    logic [1:0]  dm;
    logic [27:0] frame_m, frame2_m;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       fd;
        logic [6:0] seg2;
        logic [3:0] an2;
        logic       fd2;
    } exp_t;
    exp_t sb_q[$];

    localparam logic [27:0] LOH = {7'd56, 7'd63, 7'd118, 7'd0};

    display_scan #(
        .DIGIT_TICKS(28'd8), .BLANK_TICKS(28'd2),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .display_in(display_in), .en(en),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    display_scan #(
        .DIGIT_TICKS(28'd8), .BLANK_TICKS(28'd0),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut_pol (
        .clk(clk), .rst(rst), .display_in(display_in2), .en(1'b1),
        .seg(seg2), .an(an2), .frame_done(frame_done2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: predict, push, clock, pop, compare.
    task automatic step();
        exp_t        e;
        logic        lit;
        logic [27:0] sh;
        logic [6:0]  pat, pat2;
        if (rst) begin
            e = '{7'h7F, 4'hF, 1'b0, 7'h00, 4'h0, 1'b0};
            tm = 0; dm = 2'd0; frame_m = 28'd0; frame2_m = 28'd0;
        end else begin
            lit  = en && (tm >= 2);
            sh   = frame_m >> (7 * dm);
            pat  = sh[6:0];
            sh   = frame2_m >> (7 * dm);
            pat2 = sh[6:0];
            e.an   = lit ? ~(4'b0001 << dm) : 4'hF;
            e.seg  = lit ? ~pat : 7'h7F;
            e.fd   = (dm == 2'd3) && (tm == 7);
            e.an2  = 4'b0001 << dm;
            e.seg2 = pat2;
            e.fd2  = e.fd;
            if (dm == 2'd0 && tm == 0) begin
                frame_m  = display_in;
                frame2_m = display_in2;
            end
            if (tm == 7) begin
                tm = 0;
                dm = dm + 2'd1;
            end else begin
                tm++;
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        chk("seg", {25'd0, seg}, {25'd0, e.seg});
        chk("an", {28'd0, an}, {28'd0, e.an});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
        chk("pol_seg", {25'd0, seg2}, {25'd0, e.seg2});
        chk("pol_an", {28'd0, an2}, {28'd0, e.an2});
        chk("pol_frame_done", {31'd0, frame_done2}, {31'd0, e.fd2});
        if (frame_done) fd_count++;
        $display("[TB] cyc %0d rst=%b en=%b an=%h seg=%h fd=%b | an2=%h seg2=%h",
                 cyc, rst, en, an, seg, frame_done, an2, seg2);
    endtask

    initial begin
        int fd_before;
        int n;
        clk         = 1'b0;
        rst         = 1'b1;
        en          = 1'b1;
        display_in  = 28'hFFFFFFF;
        display_in2 = {7'd1, 7'd2, 7'd3, 7'd118};
        tm = 0; dm = 2'd0; frame_m = 28'd0; frame2_m = 28'd0;

        // Reset held: outputs blank throughout
        #1;
        chk("reset_seg", {25'd0, seg}, 32'h7F);
        chk("reset_an", {28'd0, an}, 32'hF);
        chk("reset_fd", {31'd0, frame_done}, 32'd0);
        repeat (4) step();

        // Normal scan: three full frames, one frame_done each
        rst        = 1'b0;
        display_in = LOH;
        fd_before  = fd_count;
        repeat (96) step();
        chk("scan_fd_pulses", fd_count - fd_before, 32'd3);

        // Tearing: change input during digit 1; new value only from next frame
        repeat (10) step();
        display_in = 28'd0;
        repeat (22) step();
        repeat (32) step();
        display_in = LOH;
        repeat (5) step();

        // Enable dropped for 10 cycles mid-slot; scan timing unaffected
        fd_before = fd_count;
        en = 1'b0;
        repeat (10) step();
        en = 1'b1;
        repeat (49) step();
        chk("en_fd_pulses", fd_count - fd_before, 32'd2);

        // Reset mid-operation at (d,t) = (2,5)
        n = 0;
        while (!(dm == 2'd2 && tm == 5) && n < 40) begin
            step();
            n++;
        end
        chk("reached_d2_t5", {30'd0, dm}, 32'd2);
        rst = 1'b1;
        #1;
        chk("async_seg", {25'd0, seg}, 32'h7F);
        chk("async_an", {28'd0, an}, 32'hF);
        chk("async_fd", {31'd0, frame_done}, 32'd0);
        chk("async_pol_an", {28'd0, an2}, 32'h0);
        step();
        rst = 1'b0;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (frame_done) break;
        end
        chk("fd_after_reset_cycles", n, 32'd32);
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
